// File: rtl/delay_meter.sv
// delay_meter
//   Measures the number of clock cycles between a rising edge on i_start
//   and the next rising edge on i_echo. If no echo arrives within P_TIMEOUT
//   cycles, the measurement is aborted and o_timeout pulses for one cycle.
//
//   Optional feature (macro DELAY_METER_MAX_EN): adds a running maximum of
//   the valid delays seen. i_max_clr clears it, and a clear takes priority
//   over a simultaneous update.
//
// Parameters
//   P_CNT_WIDTH : width of the delay count
//   P_TIMEOUT   : cycles without an echo before the measurement aborts
//                 (1 .. 2^P_CNT_WIDTH-1)
//
// Ports
//   i_clk       : clock, rising edge
//   i_rst_n     : asynchronous active-low reset
//   i_start     : outbound pulse; its rising edge starts a measurement
//   i_echo      : returned pulse; its rising edge ends a measurement
//   i_max_clr   : (DELAY_METER_MAX_EN only) clears o_max_delay
//   o_max_delay : (DELAY_METER_MAX_EN only) largest valid delay since clear
//   o_busy      : high while a measurement is in progress
//   o_valid     : one-cycle strobe qualifying o_delay
//   o_delay     : last measured delay in cycles
//   o_timeout   : one-cycle strobe on an aborted measurement
module delay_meter #(
    parameter int P_CNT_WIDTH = 8,
    parameter int P_TIMEOUT   = 200
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic                   i_echo,
`ifdef DELAY_METER_MAX_EN
    input  logic                   i_max_clr,
    output logic [P_CNT_WIDTH-1:0] o_max_delay,
`endif
    output logic                   o_busy,
    output logic                   o_valid,
    output logic [P_CNT_WIDTH-1:0] o_delay,
    output logic                   o_timeout
);

    localparam logic [P_CNT_WIDTH-1:0] L_TIMEOUT = P_CNT_WIDTH'(P_TIMEOUT);
    localparam logic [P_CNT_WIDTH-1:0] L_ONE     = P_CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [P_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [P_CNT_WIDTH-1:0] delay_d;
    logic                   valid_d;
    logic                   timeout_d;
    logic                   start_q;
    logic                   echo_q;
    logic                   start_edge;
    logic                   echo_edge;

    // Single-register edge detection; the inputs are assumed synchronous.
    // The edge registers are cleared by reset, so an input held high
    // through reset release produces an edge on the first posedge.
    assign start_edge = i_start & ~start_q;
    assign echo_edge  = i_echo  & ~echo_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            start_q   <= 1'b0;
            echo_q    <= 1'b0;
            o_busy    <= 1'b0;
            o_valid   <= 1'b0;
            o_timeout <= 1'b0;
            o_delay   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            start_q   <= i_start;
            echo_q    <= i_echo;
            o_busy    <= (state_d == S_MEASURE);
            o_valid   <= valid_d;
            o_timeout <= timeout_d;
            o_delay   <= delay_d;
        end
    end

    // cnt holds the number of posedges since the start edge, so an echo
    // edge seen in MEASURE captures cnt directly as the delay. The echo is
    // checked before the timeout so that a coincident echo wins.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        delay_d   = o_delay;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    cnt_d   = L_ONE;
                    state_d = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (echo_edge) begin
                    delay_d = cnt_q;
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q == L_TIMEOUT) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + L_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef DELAY_METER_MAX_EN
    // Updated on the same edge that loads o_delay, so the new maximum is
    // visible together with o_valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_max_delay <= '0;
        end else if (i_max_clr) begin
            o_max_delay <= '0;
        end else if (valid_d && (cnt_q > o_max_delay)) begin
            o_max_delay <= cnt_q;
        end
    end
`endif

endmodule

// File: doc/delay_meter.md
DELAY_METER -- requirements
Module: delay_meter

Interface
REQ-001 SHALL have parameter P_CNT_WIDTH, default 8: width of the delay count.
REQ-002 SHALL have parameter P_TIMEOUT, default 200: cycles without an echo before the measurement aborts; legal range 1 to 2^P_CNT_WIDTH-1.
REQ-003 SHALL have port i_clk, input, 1: clock; all logic rising-edge triggered.
REQ-004 SHALL have port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port i_start, input, 1: outbound pulse, whose rising edge starts a measurement.
REQ-006 SHALL have port i_echo, input, 1: returned pulse, whose rising edge ends a measurement.
REQ-007 SHALL have port o_busy, output, 1: high while a measurement is in progress.
REQ-008 SHALL have port o_valid, output, 1: one-cycle strobe qualifying o_delay.
REQ-009 SHALL have port o_delay, output, P_CNT_WIDTH: last measured delay in cycles.
REQ-010 SHALL have port o_timeout, output, 1: one-cycle strobe on an aborted measurement.

Function
REQ-011 SHALL detect edges by registering i_start and i_echo once; an edge is input=1 while the registered copy=0, both sampled at the same posedge; synchronising asynchronous inputs is the integrator's responsibility.
REQ-012 SHALL implement FSM states IDLE, MEASURE, DONE; after reset the state is IDLE.
REQ-013 IDLE: a start edge at posedge t SHALL load cnt=1 and move to MEASURE; otherwise the FSM stays in IDLE.
REQ-014 MEASURE: an echo edge at posedge t+N SHALL load o_delay=N, move to DONE and assert o_valid during the DONE cycle.
REQ-015 MEASURE without an echo edge: when cnt equals P_TIMEOUT, the FSM SHALL move to DONE, assert o_timeout during the DONE cycle and leave o_delay unchanged; otherwise cnt SHALL increment by 1.
REQ-016 An echo edge at the same posedge as the timeout check SHALL win: report as valid, no timeout.
REQ-017 DONE SHALL last exactly one cycle and then return to IDLE; o_valid and o_timeout SHALL never be high together.
REQ-018 Start edges in MEASURE or DONE SHALL be ignored; a measurement is not restarted.
REQ-019 Echo edges in IDLE or DONE SHALL be ignored; an echo edge at the same posedge as the starting start edge SHALL be ignored.
REQ-020 o_busy SHALL equal (state==MEASURE); all outputs SHALL be registered.
REQ-021 The minimum measurable delay SHALL be 1 and the maximum SHALL be P_TIMEOUT; cnt SHALL never wrap.

Reset
REQ-022 Assertion of i_rst_n SHALL immediately force state=IDLE, cnt=0, o_delay=0, o_valid=0, o_timeout=0, o_busy=0, and both edge registers=0.
REQ-023 Reset in the middle of a measurement SHALL discard it with no strobe; the first start edge after release starts a fresh measurement.
REQ-024 An input held high through reset release SHALL count as a rising edge on the first posedge after release.

Configuration
REQ-025 With macro DELAY_METER_MAX_EN defined, the block SHALL add ports i_max_clr (input, 1) and o_max_delay (output, P_CNT_WIDTH).
REQ-026 With DELAY_METER_MAX_EN defined, o_max_delay SHALL update to max(o_max_delay, N) in the cycle o_valid is asserted.
REQ-027 With DELAY_METER_MAX_EN defined, o_max_delay SHALL be cleared to 0 by reset or by i_max_clr=1; clear SHALL win over a simultaneous update.
REQ-028 With DELAY_METER_MAX_EN defined, timeouts SHALL not affect o_max_delay.
REQ-029 Without DELAY_METER_MAX_EN, these ports and their logic SHALL be absent, and the remaining behaviour SHALL be identical.

Verification
REQ-030 Start edge at posedge t, i_echo = i_start delayed by 2 cycles -> o_valid=1 at t+3, o_delay=2, o_busy high t+1..t+2.
REQ-031 Echo edge one cycle after start -> o_delay=1; echo edge coincident with start -> ignored, P_TIMEOUT=5 gives o_timeout at t+6, o_valid never asserted.
REQ-032 P_TIMEOUT=5, echo edge exactly 5 cycles after start -> o_valid with o_delay=5, no o_timeout.
REQ-033 Second start edge 3 cycles into MEASURE, echo edge 7 cycles after the first start -> single o_valid with o_delay=7.
REQ-034 Reset asserted mid-MEASURE, released, new start edge with echo edge 4 cycles later -> no strobe during reset, then o_delay=4 with o_valid.
REQ-035 DELAY_METER_MAX_EN defined, delays 3, 9, 4, then i_max_clr, then delay 2 -> o_max_delay reads 3, 9, 9, 0, 2.
